// File: rtl/elegant_storage_pkg.sv
// Shared defaults and helpers for the elegant_storage_bank register store.
package elegant_storage_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // An address is usable only below DEPTH; matters when DEPTH is not a power of two.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/storage_valid_tracker.sv
// Per-entry valid bits plus a registered occupancy count, updated on the same edge.
module storage_valid_tracker
    import elegant_storage_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clear,
    output logic [DEPTH-1:0] valid,
    output logic [CW-1:0]    valid_count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;

    // Clear and set on the same edge leave only the written entry valid.
    always_comb begin
        valid_d = clear ? '0 : valid_q;
        if (set_en) begin
            valid_d[set_idx] = 1'b1;
        end
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign valid       = valid_q;
    assign valid_count = count_q;

endmodule

// File: rtl/elegant_storage_bank.sv
// DEPTH x WIDTH store with registered read port and valid tracking.
// Define STORAGE_BYPASS_EN to forward same-edge write data to a same-address read.
module elegant_storage_bank
    import elegant_storage_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enable,
    input  logic [AW-1:0]    read_addr,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             read_valid,
    output logic             read_hit,
    output logic [CW-1:0]    valid_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             read_valid_q, read_valid_d;
    logic             read_hit_q, read_hit_d;
    logic [DEPTH-1:0] valid;
    logic             wr_ok, rd_ok;

    assign wr_ok = write_enable & addr_in_range(32'(write_addr), DEPTH);
    assign rd_ok = addr_in_range(32'(read_addr), DEPTH);

    storage_valid_tracker #(.DEPTH(DEPTH)) u_valid_tracker (
        .clk        (clk),
        .rst        (rst),
        .set_en     (wr_ok),
        .set_idx    (write_addr),
        .clear      (clear),
        .valid      (valid),
        .valid_count(valid_count)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[write_addr] = data_in;
        end
    end

    // Reads sample pre-edge contents/valid bits unless bypass forwards the write.
    always_comb begin
        data_out_d   = data_out_q;
        read_hit_d   = read_hit_q;
        read_valid_d = read_enable;
        if (read_enable) begin
            if (!rd_ok) begin
                data_out_d = '0;
                read_hit_d = 1'b0;
            end else begin
                data_out_d = mem_q[read_addr];
                read_hit_d = valid[read_addr];
`ifdef STORAGE_BYPASS_EN
                if (wr_ok && (write_addr == read_addr)) begin
                    data_out_d = data_in;
                    read_hit_d = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
            read_hit_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
            read_hit_q   <= read_hit_d;
        end
    end

    assign data_out   = data_out_q;
    assign read_valid = read_valid_q;
    assign read_hit   = read_hit_q;

endmodule

// File: tb/tb_elegant_storage_bank.sv
// Directed table-driven bench for elegant_storage_bank (WIDTH=8, DEPTH=4).
module tb_elegant_storage_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             write_enable;
    logic [AW-1:0]    write_addr;
    logic [WIDTH-1:0] data_in;
    logic             read_enable;
    logic [AW-1:0]    read_addr;
    logic             clear;
    logic [WIDTH-1:0] data_out;
    logic             read_valid;
    logic             read_hit;
    logic [CW-1:0]    valid_count;

    int n_cmp  = 0;
    int n_fail = 0;

    elegant_storage_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .write_enable(write_enable),
        .write_addr  (write_addr),
        .data_in     (data_in),
        .read_enable (read_enable),
        .read_addr   (read_addr),
        .clear       (clear),
        .data_out    (data_out),
        .read_valid  (read_valid),
        .read_hit    (read_hit),
        .valid_count (valid_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic [1:0] wa;
        logic [7:0] din;
        logic       re;
        logic [1:0] ra;
        logic       clr;
        logic [7:0] e_data;
        logic       e_rv;
        logic       e_hit;
        logic [2:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic r, logic we, logic [1:0] wa, logic [7:0] din,
                                logic re, logic [1:0] ra, logic clr,
                                logic [7:0] ed, logic erv, logic eh, logic [2:0] ec);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa; v.din = din;
        v.re = re; v.ra = ra; v.clr = clr;
        v.e_data = ed; v.e_rv = erv; v.e_hit = eh; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; write_enable = v.we; write_addr = v.wa; data_in = v.din;
        read_enable = v.re; read_addr = v.ra; clear = v.clr;
        @(posedge clk);
        #1;
        check($sformatf("v%0d data_out", idx), 32'(data_out), 32'(v.e_data));
        check($sformatf("v%0d read_valid", idx), 32'(read_valid), 32'(v.e_rv));
        check($sformatf("v%0d read_hit", idx), 32'(read_hit), 32'(v.e_hit));
        check($sformatf("v%0d valid_count", idx), 32'(valid_count), 32'(v.e_cnt));
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; write_enable = 1'b0; write_addr = '0; data_in = '0;
        read_enable = 1'b0; read_addr = '0; clear = 1'b0;

        //            rst we wa  din    re ra clr  data   rv hit cnt
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 1, 3, 8'h3C, 0, 0, 0, 8'h00, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 0, 8'h3C, 1, 1, 2));
`ifdef STORAGE_BYPASS_EN
        vecs.push_back(mk(0, 1, 2, 8'h77, 1, 2, 0, 8'h77, 1, 1, 3));
`else
        vecs.push_back(mk(0, 1, 2, 8'h77, 1, 2, 0, 8'h00, 1, 0, 3));
`endif
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 0, 8'h77, 1, 1, 3));
        vecs.push_back(mk(0, 1, 0, 8'h55, 0, 0, 0, 8'h77, 0, 1, 4));
        vecs.push_back(mk(0, 1, 0, 8'h11, 1, 3, 1, 8'h3C, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 0, 8'h3C, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h11, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 0, 0, 0, 8'h11, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 0, 0, 0, 8'h11, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'hFF, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'hFF, 0, 1, 2));
        vecs.push_back(mk(1, 1, 2, 8'h99, 1, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 3, 8'h42, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 0, 8'h42, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Fill every entry, then rewrite at full occupancy: count must stop at DEPTH.
        for (int i = 0; i < 4; i++) begin
            step(mk(0, 1, 2'(i), 8'(i * 16 + 5), 0, 0, 0, 8'h42, 0, 0, 3'(i + 1)), 100 + i);
        end
        step(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h42, 0, 0, 4), 104);
        // Back-to-back reads stream one result per cycle.
        for (int i = 0; i < 4; i++) begin
            step(mk(0, 0, 0, 8'h00, 1, 2'(i), 0, (i == 0) ? 8'h00 : 8'(i * 16 + 5), 1, 1, 4),
                 110 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
